// File: rtl/wb_pkg.sv
// Shared constants for the writeback arbiter: data width, register address width,
// the zero register, and the late-result FIFO entry layout {rd, data}.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Width of one buffered late result: rd in the top bits, data below.
  function automatic int entry_width(input int xlen);
    return REG_ADDR_W + xlen;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with asynchronous active-low reset. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: execute results win, buffered long-latency results
// drain when execute is idle; keeps the busy scoreboard. WB_PERF_EN adds perf_conflict.
module writeback_arbiter #(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            hazard,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata
`ifdef WB_PERF_EN
  ,
  output logic [31:0]     perf_conflict
`endif
);
  import wb_pkg::*;

  localparam int EW = entry_width(XLEN);

  logic                  ex_write;
  logic                  fifo_pop;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         fifo_head;
  logic [4:0]            head_rd;
  logic [XLEN-1:0]       head_data;
  logic [NUM_REGS-1:0]   busy_reg;
  logic [NUM_REGS-1:0]   busy_next;

  assign ex_write  = ex_valid && (ex_rd != REG_ZERO);
  assign fifo_pop  = !ex_write && !fifo_empty;
  // Ready comes only from registered FIFO state, never from this cycle's pop.
  assign lu_ready  = rst_n && !fifo_full;
  assign fifo_push = lu_valid && lu_ready;
  assign head_rd   = fifo_head[XLEN +: REG_ADDR_W];
  assign head_data = fifo_head[XLEN-1:0];

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({lu_rd, lu_data}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = REG_ZERO;
    rf_wdata = '0;
    if (ex_write) begin
      rf_we    = rst_n;
      rf_rd    = ex_rd;
      rf_wdata = ex_data;
    end else if (!fifo_empty) begin
      rf_we    = rst_n && (head_rd != REG_ZERO);
      rf_rd    = head_rd;
      rf_wdata = head_data;
    end
  end

  // Issue is applied after the pop clear so a same-cycle reissue keeps the bit set.
  always_comb begin
    busy_next = busy_reg;
    if (fifo_pop)    busy_next[head_rd]  = 1'b0;
    if (issue_valid) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  assign hazard = rst_n && (busy_reg[chk_rs1] || busy_reg[chk_rs2] ||
                            busy_reg[chk_rd] || fifo_full);

`ifdef WB_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        perf_reg <= '0;
    else if (ex_write && !fifo_empty)  perf_reg <= perf_reg + 32'd1;
  end

  assign perf_conflict = perf_reg;
`endif

`ifndef SYNTHESIS
  // A late result for a register nobody is waiting on is still written; just flag it.
  always_ff @(posedge clk) begin
    if (fifo_push && lu_rd != REG_ZERO)
      assert (busy_reg[lu_rd]) else $warning("late result for idle rd %0d", lu_rd);
  end
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, hand sequences for the multi-cycle
// corners, then random traffic against a queue-based reference model.
module tb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, lu_valid, issue_valid;
  logic [4:0]  ex_rd, lu_rd, issue_rd, chk_rs1, chk_rs2, chk_rd;
  logic [31:0] ex_data, lu_data;
  logic        lu_ready, hazard, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
`ifdef WB_PERF_EN
  logic [31:0] perf_conflict;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] rf_mem [32];

  always #5 clk = ~clk;

  writeback_arbiter #(.XLEN(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
`ifdef WB_PERF_EN
    , .perf_conflict(perf_conflict)
`endif
  );

  // Register file image built from the write port, as the real register file would see it.
  always @(posedge clk) if (rf_we) rf_mem[rf_rd] <= rf_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird, input logic [4:0] rs1);
    @(negedge clk);
    ex_valid = ev; ex_rd = erd; ex_data = ed;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    issue_valid = iv; issue_rd = ird;
    chk_rs1 = rs1; chk_rs2 = 5'd0; chk_rd = 5'd0;
    #1;
  endtask

  typedef struct {
    logic ev; logic [4:0] erd; logic [31:0] ed;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic iv; logic [4:0] ird; logic [4:0] rs1;
    logic we; logic [4:0] wrd; logic [31:0] wd; logic rdy; logic haz;
  } vec_t;

  function automatic vec_t mk(logic ev, logic [4:0] erd, logic [31:0] ed,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic iv, logic [4:0] ird, logic [4:0] rs1,
                              logic we, logic [4:0] wrd, logic [31:0] wd,
                              logic rdy, logic haz);
    vec_t v;
    v.ev = ev; v.erd = erd; v.ed = ed; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird; v.rs1 = rs1;
    v.we = we; v.wrd = wrd; v.wd = wd; v.rdy = rdy; v.haz = haz;
    return v;
  endfunction

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  vec_t vecs [28];

  initial begin
    ent_t        mq[$];
    bit          mbusy[32];
    int          outst[$];
    int unsigned mperf;

    // ex | lu | issue | chk_rs1 | expected we rd wdata ready hazard
    vecs[0]  = mk(1,5,32'hDEADBEEF, 0,0,0,     0,0,  0, 1,5,32'hDEADBEEF,1,0);
    vecs[1]  = mk(0,0,0,            0,0,0,     0,0,  5, 0,0,0,           1,0);
    vecs[2]  = mk(0,0,0,            0,0,0,     1,7,  7, 0,0,0,           1,0);
    vecs[3]  = mk(0,0,0,            0,0,0,     0,0,  7, 0,0,0,           1,1);
    vecs[4]  = mk(0,0,0,            1,7,32'h1234,0,0,7, 0,0,0,           1,1);
    vecs[5]  = mk(0,0,0,            0,0,0,     0,0,  7, 1,7,32'h1234,    1,1);
    vecs[6]  = mk(0,0,0,            0,0,0,     0,0,  7, 0,0,0,           1,0);
    vecs[7]  = mk(0,0,0,            0,0,0,     1,8,  0, 0,0,0,           1,0);
    vecs[8]  = mk(0,0,0,            0,0,0,     1,9,  0, 0,0,0,           1,0);
    vecs[9]  = mk(1,1,32'h11,       1,8,32'h88,0,0,  0, 1,1,32'h11,      1,0);
    vecs[10] = mk(1,2,32'h22,       1,9,32'h99,0,0,  0, 1,2,32'h22,      1,0);
    vecs[11] = mk(1,3,32'h33,       0,0,0,     0,0,  0, 1,3,32'h33,      1,0);
    vecs[12] = mk(0,0,0,            0,0,0,     0,0,  0, 1,8,32'h88,      1,0);
    vecs[13] = mk(0,0,0,            0,0,0,     0,0,  0, 1,9,32'h99,      1,0);
    vecs[14] = mk(0,0,0,            0,0,0,     0,0,  0, 0,0,0,           1,0);
    for (int i = 0; i < 4; i++)
      vecs[15+i] = mk(0,0,0, 0,0,0, 1,5'(10+i), 0, 0,0,0, 1,0);
    for (int i = 0; i < 4; i++)
      vecs[19+i] = mk(1,1,32'h101+i, 1,5'(10+i),32'hA0+i, 0,0,0, 1,1,32'h101+i, 1,0);
    vecs[23] = mk(0,0,0, 0,0,0, 0,0, 0, 1,10,32'hA0, 0,1);
    vecs[24] = mk(0,0,0, 0,0,0, 0,0, 0, 1,11,32'hA1, 1,0);
    vecs[25] = mk(0,0,0, 0,0,0, 0,0, 0, 1,12,32'hA2, 1,0);
    vecs[26] = mk(0,0,0, 0,0,0, 0,0, 0, 1,13,32'hA3, 1,0);
    vecs[27] = mk(0,0,0, 0,0,0, 0,0, 0, 0,0,0,       1,0);

    // Reset: outputs held inactive even with an execute result presented.
    rst_n = 1'b0;
    drive(1,5,32'h55, 1,0,0, 0,0, 0);
    chk("reset_rf_we", 32'(rf_we), 0);
    chk("reset_lu_ready", 32'(lu_ready), 0);
    chk("reset_hazard", 32'(hazard), 0);
    drive(0,0,0, 0,0,0, 0,0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].ev, vecs[i].erd, vecs[i].ed, vecs[i].lv, vecs[i].lrd, vecs[i].ld,
            vecs[i].iv, vecs[i].ird, vecs[i].rs1);
      $display("vec %0d: rf_we=%0b rf_rd=%0d rf_wdata=%h lu_ready=%0b hazard=%0b",
               i, rf_we, rf_rd, rf_wdata, lu_ready, hazard);
      chk($sformatf("vec%0d_rf_we", i),    32'(rf_we),    32'(vecs[i].we));
      chk($sformatf("vec%0d_rf_rd", i),    32'(rf_rd),    32'(vecs[i].wrd));
      chk($sformatf("vec%0d_rf_wdata", i), rf_wdata,      vecs[i].wd);
      chk($sformatf("vec%0d_lu_ready", i), 32'(lu_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_hazard", i),   32'(hazard),   32'(vecs[i].haz));
      if (i == 1) chk("regfile_r5", rf_mem[5], 32'hDEADBEEF);
`ifdef WB_PERF_EN
      if (i == 14) chk("perf_conflict", perf_conflict, 32'd2);
`endif
    end

    // Reissue of rd=3 in the same cycle its earlier result pops keeps it busy.
    drive(0,0,0, 0,0,0,          1,3, 0);
    drive(0,0,0, 1,3,32'h333,    0,0, 0);
    drive(0,0,0, 0,0,0,          1,3, 0);
    $display("seq5 pop: rf_we=%0b rf_rd=%0d rf_wdata=%h", rf_we, rf_rd, rf_wdata);
    chk("seq5_pop_we", 32'(rf_we), 1);
    chk("seq5_pop_data", rf_wdata, 32'h333);
    drive(0,0,0, 0,0,0,          0,0, 3);
    $display("seq5 after: hazard=%0b", hazard);
    chk("seq5_busy3_kept", 32'(hazard), 1);
    drive(0,0,0, 1,3,32'h444,    0,0, 0);
    drive(0,0,0, 0,0,0,          0,0, 0);
    chk("seq5_second_pop", rf_wdata, 32'h444);
    drive(0,0,0, 0,0,0,          0,0, 3);
    chk("seq5_busy3_cleared", 32'(hazard), 0);

    // Reset with three buffered results discards them and clears the scoreboard.
    for (int i = 0; i < 3; i++) drive(0,0,0, 0,0,0, 1,5'(20+i), 0);
    for (int i = 0; i < 3; i++) drive(1,1,32'h7, 1,5'(20+i),32'hC0+i, 0,0, 0);
    rst_n = 1'b0;
    drive(1,1,32'h7, 0,0,0, 0,0, 20);
    $display("seq6 in reset: rf_we=%0b lu_ready=%0b hazard=%0b", rf_we, lu_ready, hazard);
    chk("seq6_rst_we", 32'(rf_we), 0);
    chk("seq6_rst_ready", 32'(lu_ready), 0);
    chk("seq6_rst_hazard", 32'(hazard), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,0, 0,0,0, 0,0, 21);
    $display("seq6 released: rf_we=%0b lu_ready=%0b hazard=%0b", rf_we, lu_ready, hazard);
    chk("seq6_fifo_empty", 32'(rf_we), 0);
    chk("seq6_ready", 32'(lu_ready), 1);
    chk("seq6_busy_clear", 32'(hazard), 0);
`ifdef WB_PERF_EN
    chk("seq6_perf_reset", perf_conflict, 0);
`endif

    // Random traffic against the reference model; state is empty after the reset above.
    mq.delete(); outst.delete(); mperf = 0;
    for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [4:0]  rs1, rs2, crd;
      logic        ev, lv, iv, full_m, haz_m, exw, pop, push;
      logic [4:0]  erd, lrd, ird;
      logic [31:0] ed, ld;
      logic        e_we;
      logic [4:0]  e_rd;
      logic [31:0] e_wd;
      int          lidx;
      ent_t        e;

      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      crd = 5'($urandom_range(0, 31));
      full_m = (mq.size() == 4);
      haz_m  = mbusy[rs1] || mbusy[rs2] || mbusy[crd] || full_m;
      ev  = !haz_m && ($urandom_range(0, 1) == 1);
      erd = 5'($urandom_range(0, 31));
      ed  = $urandom;
      iv  = 1'b0; ird = 5'd0;
      if (!haz_m && $urandom_range(0, 3) == 0) begin
        ird = 5'($urandom_range(1, 31));
        iv  = !mbusy[ird];
      end
      lv = 1'b0; lrd = 5'd0; ld = $urandom; lidx = -1;
      if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
        lidx = $urandom_range(0, outst.size() - 1);
        lv = 1'b1; lrd = 5'(outst[lidx]);
      end else if ($urandom_range(0, 19) == 0) begin
        lv = 1'b1;
      end

      @(negedge clk);
      ex_valid = ev; ex_rd = erd; ex_data = ed;
      lu_valid = lv; lu_rd = lrd; lu_data = ld;
      issue_valid = iv; issue_rd = ird;
      chk_rs1 = rs1; chk_rs2 = rs2; chk_rd = crd;
      #1;

      exw = ev && (erd != 5'd0);
      if (exw) begin
        e_we = 1'b1; e_rd = erd; e_wd = ed;
      end else if (mq.size() > 0) begin
        e_we = (mq[0].rd != 5'd0); e_rd = mq[0].rd; e_wd = mq[0].data;
      end else begin
        e_we = 1'b0; e_rd = 5'd0; e_wd = 32'd0;
      end
      chk("rand_rf_we",    32'(rf_we),    32'(e_we));
      chk("rand_rf_rd",    32'(rf_rd),    32'(e_rd));
      chk("rand_rf_wdata", rf_wdata,      e_wd);
      chk("rand_lu_ready", 32'(lu_ready), 32'(!full_m));
      chk("rand_hazard",   32'(hazard),   32'(haz_m));
`ifdef WB_PERF_EN
      chk("rand_perf", perf_conflict, mperf);
`endif

      pop  = !exw && (mq.size() > 0);
      push = lv && !full_m;
      if (exw && mq.size() > 0) mperf++;
      if (pop) begin
        e = mq.pop_front();
        mbusy[e.rd] = 1'b0;
      end
      if (push) begin
        e.rd = lrd; e.data = ld;
        mq.push_back(e);
        if (lidx >= 0) outst.delete(lidx);
      end
      if (iv) begin
        mbusy[ird] = 1'b1;
        outst.push_back(int'(ird));
      end
      mbusy[0] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
